// File: rtl/m_ifetch.sv
`default_nettype none
// m_ifetch: PC holder, imem addressing and DEPTH-entry {pc, ir} fetch FIFO with redirect flush.
// Optional macro IFETCH_STATS_EN adds fetch/stall counters.  Rev 1.0
module m_ifetch #(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     w_clk,
  input  logic                     w_rst_n,
  output logic [ADDR_W-1:0]        w_imem_addr,
  input  logic [31:0]              w_imem_data,
  input  logic                     w_redirect,
  input  logic [31:0]              w_target,
  input  logic                     w_ready,
  output logic                     w_valid,
  output logic [31:0]              w_ir,
  output logic [31:0]              w_pc,
  output logic [$clog2(DEPTH):0]   w_count
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0]              w_stat_fetch,
  output logic [31:0]              w_stat_stall
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [31:0]     pc;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     mem_pc [DEPTH];
  logic [31:0]     mem_ir [DEPTH];
  logic            pop, push;
  logic            unused_target_lsbs;

  assign unused_target_lsbs = &{1'b0, w_target[1:0]};

  assign w_imem_addr = pc[ADDR_W+1:2];
  assign w_valid     = (count != '0);
  assign w_count     = count;
  assign w_pc        = mem_pc[rd_ptr];
  assign w_ir        = mem_ir[rd_ptr];

  // Redirect suppresses both sides of the FIFO; a pop can free a slot for a same-cycle push.
  assign pop  = w_valid & w_ready & ~w_redirect;
  assign push = (state == S_RUN) & ~w_redirect & ((count < CW'(DEPTH)) | pop);

  always_comb begin
    state_nxt = state;
    if (w_redirect) begin
      state_nxt = S_FLUSH;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_RUN;
        S_FLUSH: state_nxt = S_RUN;
        S_RUN:   state_nxt = S_RUN;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i] <= '0;
        mem_ir[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (w_redirect) begin
        pc     <= {w_target[31:2], 2'b00};
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          mem_pc[wr_ptr] <= pc;
          mem_ir[wr_ptr] <= w_imem_data;
          wr_ptr         <= wr_ptr + 1'b1;
          pc             <= pc + 32'd4;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

`ifdef IFETCH_STATS_EN
  logic stall;
  assign stall = (state == S_RUN) & (count == CW'(DEPTH)) & ~(w_valid & w_ready);

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      w_stat_fetch <= '0;
      w_stat_stall <= '0;
    end else begin
      w_stat_fetch <= w_stat_fetch + 32'(push);
      w_stat_stall <= w_stat_stall + 32'(stall);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_m_ifetch.sv
`default_nettype none
// tb_m_ifetch: vector table for startup/backpressure/redirect/reset, then random traffic vs a queue model.
module tb_m_ifetch;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              redirect = 1'b0;
  logic [31:0]       target = '0;
  logic              ready = 1'b1;
  logic              valid;
  logic [31:0]       ir, pc;
  logic [2:0]        count;
  logic [31:0]       salt = '0;
`ifdef IFETCH_STATS_EN
  logic [31:0]       stat_fetch, stat_stall;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [ADDR_W-1:0] a, input logic [31:0] s);
    return (32'(a) + 32'd1) ^ s;
  endfunction

  assign imem_data = imem_word(imem_addr, salt);

  m_ifetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
    .w_clk       (clk),
    .w_rst_n     (rst_n),
    .w_imem_addr (imem_addr),
    .w_imem_data (imem_data),
    .w_redirect  (redirect),
    .w_target    (target),
    .w_ready     (ready),
    .w_valid     (valid),
    .w_ir        (ir),
    .w_pc        (pc),
    .w_count     (count)
`ifdef IFETCH_STATS_EN
    ,
    .w_stat_fetch(stat_fetch),
    .w_stat_stall(stat_stall)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: fetched {pc, ir} pairs in program order.
  logic [63:0] q[$];
  logic [31:0] m_pc = '0;
  bit          m_fetch_ok = 0;
  logic [31:0] m_fetch = '0, m_stall = '0;

  task automatic model_step();
    bit do_pop, do_push;
    if (!rst_n) begin
      q.delete();
      m_pc = 32'h0;
      m_fetch_ok = 0;
      m_fetch = '0;
      m_stall = '0;
    end else begin
      if (m_fetch_ok && q.size() == DEPTH && !ready) m_stall++;
      if (redirect) begin
        q.delete();
        m_pc = target & 32'hFFFF_FFFC;
        m_fetch_ok = 0;
      end else begin
        do_pop  = (q.size() > 0) && ready;
        do_push = m_fetch_ok && (q.size() < DEPTH || do_pop);
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          q.push_back({m_pc, imem_word(m_pc[ADDR_W+1:2], salt)});
          m_pc = m_pc + 32'd4;
          m_fetch++;
        end
        m_fetch_ok = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
`ifdef IFETCH_STATS_EN
    chk("stat_fetch", stat_fetch, m_fetch);
    chk("stat_stall", stat_stall, m_stall);
`endif
  endtask

  typedef struct {
    logic        rst_n, redirect, ready;
    logic [31:0] target;
    logic        exp_valid;
    logic [2:0]  exp_count;
    logic [11:0] exp_addr;
    bit          chk_head;
    logic [31:0] exp_pc, exp_ir;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic rd, input logic [31:0] t, input logic rdy,
                     input logic v, input logic [2:0] c, input logic [11:0] a,
                     input bit h, input logic [31:0] p, input logic [31:0] i);
    vec_t e;
    e.rst_n = r; e.redirect = rd; e.target = t; e.ready = rdy;
    e.exp_valid = v; e.exp_count = c; e.exp_addr = a; e.chk_head = h; e.exp_pc = p; e.exp_ir = i;
    vq.push_back(e);
  endtask

  initial begin
    // Startup with imem[k]=k+1
    add(0,0,0,1, 0,0,12'h000, 1,32'h0,32'h0);
    add(0,0,0,1, 0,0,12'h000, 1,32'h0,32'h0);
    add(1,0,0,1, 0,0,12'h000, 0,0,0);
    add(1,0,0,1, 1,1,12'h001, 1,32'h0,32'h1);
    add(1,0,0,1, 1,1,12'h002, 1,32'h4,32'h2);
    add(1,0,0,1, 1,1,12'h003, 1,32'h8,32'h3);
    // Drain via redirect to 0, then backpressure from empty
    add(1,1,0,1, 0,0,12'h000, 0,0,0);
    add(1,0,0,1, 0,0,12'h000, 0,0,0);
    add(1,0,0,0, 1,1,12'h001, 1,32'h0,32'h1);
    add(1,0,0,0, 1,2,12'h002, 1,32'h0,32'h1);
    add(1,0,0,0, 1,3,12'h003, 1,32'h0,32'h1);
    add(1,0,0,0, 1,4,12'h004, 1,32'h0,32'h1);
    add(1,0,0,0, 1,4,12'h004, 1,32'h0,32'h1);
    add(1,0,0,0, 1,4,12'h004, 1,32'h0,32'h1);
    // Full with pop: count stays at DEPTH, pcs in order
    add(1,0,0,1, 1,4,12'h005, 1,32'h4,32'h2);
    add(1,0,0,1, 1,4,12'h006, 1,32'h8,32'h3);
    add(1,0,0,1, 1,4,12'h007, 1,32'hC,32'h4);
    add(1,0,0,1, 1,4,12'h008, 1,32'h10,32'h5);
    // Redirect to misaligned target with three entries buffered
    add(1,1,0,1, 0,0,12'h000, 0,0,0);
    add(1,0,0,1, 0,0,12'h000, 0,0,0);
    add(1,0,0,0, 1,1,12'h001, 1,32'h0,32'h1);
    add(1,0,0,0, 1,2,12'h002, 1,32'h0,32'h1);
    add(1,0,0,0, 1,3,12'h003, 1,32'h0,32'h1);
    add(1,1,32'h103,0, 0,0,12'h040, 0,0,0);
    add(1,0,0,0, 0,0,12'h040, 0,0,0);
    add(1,0,0,0, 1,1,12'h041, 1,32'h100,32'h41);
    add(1,0,0,0, 1,2,12'h042, 1,32'h100,32'h41);
    // Reset dominates a concurrent redirect
    add(0,1,32'h200,1, 0,0,12'h000, 1,32'h0,32'h0);
    add(1,0,0,1, 0,0,12'h000, 0,0,0);
    add(1,0,0,1, 1,1,12'h001, 1,32'h0,32'h1);

    foreach (vq[n]) begin
      rst_n = vq[n].rst_n; redirect = vq[n].redirect; target = vq[n].target; ready = vq[n].ready;
      tick();
      chk($sformatf("v%0d valid", n), 32'(valid), 32'(vq[n].exp_valid));
      chk($sformatf("v%0d count", n), 32'(count), 32'(vq[n].exp_count));
      chk($sformatf("v%0d imem_addr", n), 32'(imem_addr), 32'(vq[n].exp_addr));
      if (vq[n].chk_head) begin
        chk($sformatf("v%0d pc", n), pc, vq[n].exp_pc);
        chk($sformatf("v%0d ir", n), ir, vq[n].exp_ir);
      end
      #4;
    end

    // Random traffic, including targets near the top of the address space
    for (int n = 0; n < 600; n++) begin
      int sel;
      rst_n    = ($urandom_range(0, 79) != 0);
      redirect = ($urandom_range(0, 15) == 0);
      ready    = ($urandom_range(0, 2) != 0);
      sel      = $urandom_range(0, 2);
      target   = (sel == 0) ? $urandom() :
                 (sel == 1) ? (32'hFFFF_FFE0 + 32'($urandom_range(0, 31))) :
                              (32'h0000_3FE0 + 32'($urandom_range(0, 31)));
      if (n % 97 == 0) salt = $urandom();
      tick();
      chk("rnd valid", 32'(valid), 32'(q.size() != 0));
      chk("rnd count", 32'(count), 32'(q.size()));
      chk("rnd imem_addr", 32'(imem_addr), 32'(m_pc[ADDR_W+1:2]));
      if (q.size() != 0) begin
        chk("rnd pc", pc, q[0][63:32]);
        chk("rnd ir", ir, q[0][31:0]);
      end
      #4;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
